data_cache: RTL

Direct-mapped, write-back, write-allocate L1 data cache. It sits between the CPU MEM stage's data port (READ/WRITE/ADDR/WRITE_DATA/READ_DATA/BUSYWAIT) and a 128-bit block-wide main memory. It resolves hits with zero stall cycles, performs load sign/zero extension and byte/halfword store merging, and holds the CPU with BUSYWAIT during refill or writeback.

---
 rtl/data_cache.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/data_cache.sv
// rtl/data_cache.sv - direct-mapped write-back write-allocate L1 data cache (optional DCACHE_PERF_CNT_EN hit/miss counters)
module data_cache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [3:0]   READ,
    input  logic [2:0]   WRITE,
    input  logic [31:0]  ADDR,
    input  logic [31:0]  WRITE_DATA,
    output logic [31:0]  READ_DATA,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic         MEM_WRITE,
    output logic [27:0]  MEM_ADDRESS,
    output logic [127:0] MEM_WRITEDATA,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
`endif
);

    localparam int TAG_BITS = 28 - INDEX_BITS;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_FETCH, S_ALLOCATE} state_t;

    state_t              state;
    state_t              next_state;
    logic [LINES-1:0]    valid_bits;
    logic [LINES-1:0]    dirty_bits;
    logic [TAG_BITS-1:0] tag_array [LINES];
    logic [127:0]        data_array [LINES];
    logic [127:0]        fill_block;

    logic [TAG_BITS-1:0]   addr_tag;
    logic [INDEX_BITS-1:0] addr_index;
    logic [1:0]            addr_word;
    logic                  is_store;
    logic                  is_load;
    logic                  access;
    logic                  hit;
    logic                  victim_dirty;
    logic [127:0]          cur_line;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;
    logic [127:0]          merged_line;
    logic [7:0]            load_byte;
    logic [15:0]           load_half;

    assign addr_tag     = ADDR[31:4+INDEX_BITS];
    assign addr_index   = ADDR[3+INDEX_BITS:4];
    assign addr_word    = ADDR[3:2];
    // A store takes priority when both enables are raised together.
    assign is_store     = WRITE[2];
    assign is_load      = READ[3] && !WRITE[2];
    assign access       = is_store || is_load;
    assign hit          = access && valid_bits[addr_index] && (tag_array[addr_index] == addr_tag);
    assign victim_dirty = valid_bits[addr_index] && dirty_bits[addr_index];
    assign cur_line     = data_array[addr_index];
    assign cur_word     = cur_line[{addr_word, 5'b00000} +: 32];

    // Store merge: replace the addressed byte/halfword/word inside the selected line.
    always_comb begin
        merged_word = cur_word;
        case (WRITE[1:0])
            2'b00:   merged_word[{ADDR[1:0], 3'b000} +: 8]  = WRITE_DATA[7:0];
            2'b01:   merged_word[{ADDR[1], 4'b0000} +: 16]  = WRITE_DATA[15:0];
            default: merged_word                            = WRITE_DATA;
        endcase
        merged_line = cur_line;
        merged_line[{addr_word, 5'b00000} +: 32] = merged_word;
    end

    // Load extraction with sign/zero extension; zero whenever no load is in flight.
    always_comb begin
        load_byte = cur_word[{ADDR[1:0], 3'b000} +: 8];
        load_half = cur_word[{ADDR[1], 4'b0000} +: 16];
        READ_DATA = 32'd0;
        if (is_load) begin
            case (READ[2:0])
                3'b000:  READ_DATA = {{24{load_byte[7]}}, load_byte};
                3'b001:  READ_DATA = {{16{load_half[15]}}, load_half};
                3'b100:  READ_DATA = {24'd0, load_byte};
                3'b101:  READ_DATA = {16'd0, load_half};
                default: READ_DATA = cur_word;
            endcase
        end
    end

    // Next-state and CPU stall: a miss stalls from its first cycle until the replayed hit.
    always_comb begin
        next_state = state;
        BUSYWAIT   = 1'b0;
        case (state)
            S_IDLE: begin
                if (access && !hit) begin
                    BUSYWAIT   = 1'b1;
                    next_state = victim_dirty ? S_WRITEBACK : S_FETCH;
                end
            end
            S_WRITEBACK: begin
                BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT) next_state = S_FETCH;
            end
            S_FETCH: begin
                BUSYWAIT = 1'b1;
                if (!MEM_BUSYWAIT) next_state = S_ALLOCATE;
            end
            S_ALLOCATE: begin
                BUSYWAIT   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
        if (RESET) BUSYWAIT = 1'b0;
    end

    // State register and registered memory requests, raised on entry and held until accepted.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state         <= S_IDLE;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= 28'd0;
            MEM_WRITEDATA <= 128'd0;
        end else begin
            state <= next_state;
            case (state)
                S_IDLE: begin
                    if (access && !hit) begin
                        if (victim_dirty) begin
                            MEM_WRITE     <= 1'b1;
                            MEM_ADDRESS   <= {tag_array[addr_index], addr_index};
                            MEM_WRITEDATA <= cur_line;
                        end else begin
                            MEM_READ    <= 1'b1;
                            MEM_ADDRESS <= ADDR[31:4];
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (!MEM_BUSYWAIT) begin
                        MEM_WRITE   <= 1'b0;
                        MEM_READ    <= 1'b1;
                        MEM_ADDRESS <= ADDR[31:4];
                    end
                end
                S_FETCH: begin
                    if (!MEM_BUSYWAIT) MEM_READ <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Capture the fetched block in the cycle the memory completes the read.
    always_ff @(posedge CLK) begin
        if (state == S_FETCH && !MEM_BUSYWAIT) fill_block <= MEM_READDATA;
    end

    // Line array: refill installs a clean line; a store hit merges its bytes and marks the line dirty.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (state == S_ALLOCATE) begin
            valid_bits[addr_index] <= 1'b1;
            dirty_bits[addr_index] <= 1'b0;
            tag_array[addr_index]  <= addr_tag;
            data_array[addr_index] <= fill_block;
        end else if (state == S_IDLE && hit && is_store) begin
            dirty_bits[addr_index] <= 1'b1;
            data_array[addr_index] <= merged_line;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic refill_replay;

    // Count each access once: the replayed hit that follows a refill was already counted as a miss.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HIT_COUNT     <= 32'd0;
            MISS_COUNT    <= 32'd0;
            refill_replay <= 1'b0;
        end else begin
            refill_replay <= (state == S_ALLOCATE);
            if (state == S_IDLE && hit && !refill_replay) HIT_COUNT <= HIT_COUNT + 32'd1;
            if (state == S_IDLE && access && !hit) MISS_COUNT <= MISS_COUNT + 32'd1;
        end
    end
`endif

endmodule
